// File: rtl/vga_if.sv
// Pattern-generator pin bundle: mode/colour controls in, VGA timing and pixel stream out.
// master = the generator, slave = whatever sits on the connector side.
interface vga_if #(
  parameter int COLOR_BITS = 4,
  parameter int X_W        = 10,
  parameter int Y_W        = 10
);
  logic [1:0]              mode;
  logic [3*COLOR_BITS-1:0] fg_color;
  logic                    hsync;
  logic                    vsync;
  logic [COLOR_BITS-1:0]   vga_r;
  logic [COLOR_BITS-1:0]   vga_g;
  logic [COLOR_BITS-1:0]   vga_b;
  logic                    de;
  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic                    frame_start;

  modport master (
    input  mode, fg_color,
    output hsync, vsync, vga_r, vga_g, vga_b, de, x, y, frame_start
  );

  modport slave (
    output mode, fg_color,
    input  hsync, vsync, vga_r, vga_g, vga_b, de, x, y, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator with a pixel-enable divider.
// All outputs are one registered stage behind the h/v counters and change only on pix_en.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int CELL_LOG2  = 5
) (
  input logic   clk,
  input logic   reset,
  vga_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE >> 3;
  localparam int BAR_CW  = $clog2(BAR_W + 1);
  localparam int CB      = COLOR_BITS;

  localparam logic [X_W-1:0]    H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]    H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]    H_EDGE   = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0]    H_SYNC_S = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]    H_SYNC_E = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]    V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]    V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    V_EDGE   = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0]    V_SYNC_S = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]    V_SYNC_E = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);
  localparam logic              HS_ACT   = 1'(HSYNC_POL);
  localparam logic              VS_ACT   = 1'(VSYNC_POL);
  localparam logic [CB-1:0]     ONES     = '1;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_GRID    = 2'd3
  } pattern_e;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [X_W-1:0]    h_cnt_q, h_cnt_d;
  logic [Y_W-1:0]    v_cnt_q, v_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [BAR_CW-1:0] bar_cnt_q, bar_cnt_d;
  pattern_e          mode_q, mode_d;
  logic [3*CB-1:0]   fg_q, fg_d;

  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic [3*CB-1:0]   rgb_q, rgb_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              frame_start_q, frame_start_d;

  logic              pix_en, h_wrap, v_wrap;
  logic              de_n, hs_n, vs_n;
  logic [3*CB-1:0]   rgb_n;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    pix_en = (CLK_DIV == 1) ? 1'b1 : (div_cnt_q == DIV_LAST);
    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);

    div_cnt_d     = pix_en ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    bar_idx_d     = bar_idx_q;
    bar_cnt_d     = bar_cnt_q;
    mode_d        = mode_q;
    fg_d          = fg_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    rgb_d         = rgb_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;

    de_n = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_n = ((h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E)) ? HS_ACT : ~HS_ACT;
    vs_n = ((v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E)) ? VS_ACT : ~VS_ACT;

    rgb_n = '0;
    unique case (mode_q)
      PAT_SOLID:   rgb_n = fg_q;
      PAT_BARS:    rgb_n = {bar_idx_q[1] ? '0 : ONES,
                            bar_idx_q[2] ? '0 : ONES,
                            bar_idx_q[0] ? '0 : ONES};
      PAT_CHECKER: rgb_n = (h_cnt_q[CELL_LOG2] ^ v_cnt_q[CELL_LOG2]) ? '0 : fg_q;
      PAT_GRID:    rgb_n = ((h_cnt_q[CELL_LOG2-1:0] == '0) || (v_cnt_q[CELL_LOG2-1:0] == '0) ||
                            (h_cnt_q == H_EDGE) || (v_cnt_q == V_EDGE)) ? fg_q : '0;
      default:     rgb_n = '0;
    endcase
    if (!de_n) rgb_n = '0;

    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + X_W'(1);
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + Y_W'(1);

      // Bar index tracks h_cnt without a divider; bar 7 stops advancing and absorbs the remainder.
      if (h_wrap) begin
        bar_idx_d = '0;
        bar_cnt_d = '0;
      end else if (bar_idx_q != 3'd7) begin
        if (bar_cnt_q == BAR_LAST) begin
          bar_idx_d = bar_idx_q + 3'd1;
          bar_cnt_d = '0;
        end else begin
          bar_cnt_d = bar_cnt_q + BAR_CW'(1);
        end
      end

      if (h_wrap && v_wrap) begin
        mode_d = pattern_e'(bus.mode);
        fg_d   = bus.fg_color;
      end

      hsync_d       = hs_n;
      vsync_d       = vs_n;
      de_d          = de_n;
      rgb_d         = rgb_n;
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_idx_q     <= '0;
      bar_cnt_q     <= '0;
      mode_q        <= pattern_e'(bus.mode);
      fg_q          <= bus.fg_color;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bar_idx_q     <= bar_idx_d;
      bar_cnt_q     <= bar_cnt_d;
      mode_q        <= mode_d;
      fg_q          <= fg_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.vga_r       = rgb_q[3*CB-1:2*CB];
  assign bus.vga_g       = rgb_q[2*CB-1:CB];
  assign bus.vga_b       = rgb_q[CB-1:0];
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a 16x8 total raster: a cycle scoreboard fed by a closed-form
// timing model, a pixel vector table, and hand-written reset / timing / latching sequences.
module tb_vga_pattern_gen;

  localparam int HT    = 16;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] x;
    logic [2:0] y;
    logic       fs;
  } out_t;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    int          px;
    int          py;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  vga_if #(.COLOR_BITS(4), .X_W(4), .Y_W(3)) bus_a ();
  vga_if #(.COLOR_BITS(4), .X_W(4), .Y_W(3)) bus_b ();

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_BITS(4), .CLK_DIV(2), .CELL_LOG2(1)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(0), .COLOR_BITS(4), .CLK_DIV(1), .CELL_LOG2(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  function automatic out_t sample(input int s);
    out_t o;
    if (s == 0) o = '{bus_a.hsync, bus_a.vsync, bus_a.de, bus_a.vga_r, bus_a.vga_g,
                      bus_a.vga_b, bus_a.x, bus_a.y, bus_a.frame_start};
    else        o = '{bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.vga_r, bus_b.vga_g,
                      bus_b.vga_b, bus_b.x, bus_b.y, bus_b.frame_start};
    return o;
  endfunction

  // Expected pin values for counter position (h,v), written straight from the pattern definitions.
  function automatic out_t decode(input int h, input int v, input logic [1:0] m,
                                  input logic [11:0] fg, input bit hpol);
    out_t o;
    int   i;
    o    = '0;
    o.x  = 4'(h);
    o.y  = 3'(v);
    o.fs = (h == 0) && (v == 0);
    o.hs = (h >= 10 && h < 13) ? hpol : !hpol;
    o.vs = !(v >= 5 && v < 7);
    o.de = (h < 8) && (v < 4);
    if (o.de) begin
      case (m)
        2'd0: {o.r, o.g, o.b} = fg;
        2'd1: begin
          i   = (h > 7) ? 7 : h;
          o.r = i[1] ? 4'h0 : 4'hF;
          o.g = i[2] ? 4'h0 : 4'hF;
          o.b = i[0] ? 4'h0 : 4'hF;
        end
        2'd2: if ((((h / 2) + (v / 2)) % 2) == 0) {o.r, o.g, o.b} = fg;
        default: if ((h % 2 == 0) || (v % 2 == 0) || h == 7 || v == 3) {o.r, o.g, o.b} = fg;
      endcase
    end
    return o;
  endfunction

  int          t_m [2];
  out_t        cur_m [2];
  logic [1:0]  mm [2];
  logic [11:0] fm [2];
  out_t        sb_a [$];
  out_t        sb_b [$];

  // Model keyed on clk edges since reset release: pixel p loads on edge (p+1)*div.
  task automatic model_step(input int s, input logic rst, input logic [1:0] m,
                            input logic [11:0] fg, input int div, input bit hpol,
                            output out_t e);
    int p, h, v;
    if (rst) begin
      t_m[s]      = 0;
      mm[s]       = m;
      fm[s]       = fg;
      cur_m[s]    = '0;
      cur_m[s].hs = !hpol;
      cur_m[s].vs = 1'b1;
    end else begin
      t_m[s]++;
      cur_m[s].fs = 1'b0;
      if (t_m[s] >= div && (t_m[s] % div) == 0) begin
        p        = t_m[s] / div - 1;
        h        = p % HT;
        v        = (p / HT) % VT;
        cur_m[s] = decode(h, v, mm[s], fm[s], hpol);
        if (h == HT - 1 && v == VT - 1) begin
          mm[s] = m;
          fm[s] = fg;
        end
      end
    end
    e = cur_m[s];
  endtask

  always @(posedge clk) begin : sb_push
    out_t e;
    model_step(0, rst_a, bus_a.mode, bus_a.fg_color, 2, 1'b0, e);
    sb_a.push_back(e);
    model_step(1, rst_b, bus_b.mode, bus_b.fg_color, 1, 1'b1, e);
    sb_b.push_back(e);
  end

  always @(negedge clk) begin : sb_pop
    out_t e;
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      check("sb_a", 64'(sample(0)), 64'(e));
    end
    if (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      check("sb_b", 64'(sample(1)), 64'(e));
    end
  end

  task automatic wait_pix(input int s, input int px, input int py, input int budget, output bit ok);
    out_t o;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      o = sample(s);
      if (o.x == 4'(px) && o.y == 3'(py)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout($sformatf("wait_pix_%0d_%0d_%0d", s, px, py));
  endtask

  task automatic wait_fs(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sample(s).fs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout($sformatf("wait_fs_%0d", s));
  endtask

  vec_t vecs [$];

  task automatic run_vectors(input int s);
    bit   ok;
    out_t o;
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].sel != s) continue;
      if (s == 0 && vecs[k].mode != bus_a.mode) begin
        bus_a.mode = vecs[k].mode;
        wait_fs(0, 600, ok);
      end
      wait_pix(s, vecs[k].px, vecs[k].py, 600, ok);
      if (ok) begin
        o = sample(s);
        check($sformatf("vec%0d_rgb", k), 64'({o.r, o.g, o.b}), 64'(vecs[k].rgb));
      end
    end
  endtask

  initial begin : main
    out_t o;
    out_t rst_val;
    bit   ok;
    int   cnt, hs_low, de_hi, vs_low, first_hs, first_vs, rgb_bad, hs_hi, first_hb;

    // mode latch (A, checker), colour bars (A), grid with pol/div change (B)
    vecs.push_back('{0, 2'd2, 0, 0, 12'hF00});
    vecs.push_back('{0, 2'd2, 2, 0, 12'h000});
    vecs.push_back('{0, 2'd2, 2, 2, 12'hF00});
    vecs.push_back('{0, 2'd1, 0, 0, 12'hFFF});
    vecs.push_back('{0, 2'd1, 1, 0, 12'hFF0});
    vecs.push_back('{0, 2'd1, 2, 0, 12'h0FF});
    vecs.push_back('{0, 2'd1, 3, 0, 12'h0F0});
    vecs.push_back('{0, 2'd1, 4, 0, 12'hF0F});
    vecs.push_back('{0, 2'd1, 5, 0, 12'hF00});
    vecs.push_back('{0, 2'd1, 6, 0, 12'h00F});
    vecs.push_back('{0, 2'd1, 7, 0, 12'h000});
    vecs.push_back('{1, 2'd3, 0, 0, 12'h0F0});
    vecs.push_back('{1, 2'd3, 5, 0, 12'h0F0});
    vecs.push_back('{1, 2'd3, 0, 1, 12'h0F0});
    vecs.push_back('{1, 2'd3, 7, 1, 12'h0F0});
    vecs.push_back('{1, 2'd3, 1, 1, 12'h000});
    vecs.push_back('{1, 2'd3, 3, 1, 12'h000});
    vecs.push_back('{1, 2'd3, 9, 1, 12'h000});
    vecs.push_back('{1, 2'd3, 3, 3, 12'h0F0});

    rst_a          = 1'b1;
    rst_b          = 1'b1;
    bus_a.mode     = 2'd0;
    bus_a.fg_color = 12'hF00;
    bus_b.mode     = 2'd3;
    bus_b.fg_color = 12'h0F0;

    rst_val    = '0;
    rst_val.hs = 1'b1;
    rst_val.vs = 1'b1;

    // Reset and first frame
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("hold_outputs", 64'(sample(0)), 64'(rst_val));
    @(negedge clk);
    o = sample(0);
    check("first_fs", 64'(o.fs), 64'd1);
    check("first_xy", 64'({o.x, o.y}), 64'd0);
    @(negedge clk);
    check("fs_one_clk", 64'(sample(0).fs), 64'd0);

    cnt = 1;
    ok  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cnt++;
      if (sample(0).fs) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) check("fs_period", 64'(cnt), 64'd256);
    else timeout("fs_period");

    // Line / frame timing over one solid frame; mode request to checker arrives at y=1
    hs_low = 0; de_hi = 0; vs_low = 0; rgb_bad = 0; first_hs = -1; first_vs = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      o = sample(0);
      if (i < 2 * HT) begin
        if (!o.hs) begin
          hs_low++;
          if (first_hs < 0) first_hs = int'(o.x);
        end
        if (o.de) de_hi++;
      end
      if (!o.vs) begin
        vs_low++;
        if (first_vs < 0) first_vs = int'(o.y);
      end
      if (((o.r == 4'hF) != o.de) || o.g != 4'h0 || o.b != 4'h0) rgb_bad++;
      if (i == 40) bus_a.mode = 2'd2;
      @(negedge clk);
    end
    check("hsync_low_clk", 64'(hs_low), 64'd6);
    check("hsync_start_x", 64'(first_hs), 64'd10);
    check("de_high_clk", 64'(de_hi), 64'd16);
    check("vsync_low_clk", 64'(vs_low), 64'd64);
    check("vsync_start_y", 64'(first_vs), 64'd5);
    check("solid_frame_rgb", 64'(rgb_bad), 64'd0);

    run_vectors(0);

    // Mid-frame reset at (5,2)
    wait_pix(0, 5, 2, 600, ok);
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_values", 64'(sample(0)), 64'(rst_val));
    rst_a = 1'b0;
    @(negedge clk);
    check("midrst_no_fs", 64'(sample(0).fs), 64'd0);
    @(negedge clk);
    o = sample(0);
    check("midrst_fs", 64'(o.fs), 64'd1);
    check("midrst_xy", 64'({o.x, o.y}), 64'd0);

    // Grid, active-high hsync, CLK_DIV=1
    rst_b = 1'b0;
    wait_fs(1, 300, ok);
    run_vectors(1);
    wait_fs(1, 300, ok);
    hs_hi = 0;
    first_hb = -1;
    for (int i = 0; i < HT; i++) begin
      o = sample(1);
      if (o.hs) begin
        hs_hi++;
        if (first_hb < 0) first_hb = int'(o.x);
      end
      @(negedge clk);
    end
    check("b_hsync_high_clk", 64'(hs_hi), 64'd3);
    check("b_hsync_start_x", 64'(first_hb), 64'd10);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
